rom_ram_copy_engine: RTL and testbench

- Parametrised ROM-to-RAM block-copy sequencer; successor to the fixed 16-word, 1-cycle-latency control/ROM pair.
- On a start pulse it copies `len` words from a synchronous-read source ROM, beginning at `src_base`, into a RAM beginning at `dst_base`.
- It supports configurable widths, configurable source read latency and an optional reversed destination order.
- A delay line aligns the write strobe and destination address with the returned read data.

---
 rtl/rom_ram_copy_engine_pkg.sv | 21 ++
 rtl/rom_ram_copy_engine_if.sv | 29 ++
 rtl/rom_ram_copy_engine_delay.sv | 32 +++
 rtl/rom_ram_copy_engine.sv | 118 +++++++++++
 tb/tb_rom_ram_copy_engine.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_ram_copy_engine_pkg.sv
// Shared types and helpers for the ROM-to-RAM block-copy engine.
// Holds the sequencer state encoding, the read-latency ceiling and destination address arithmetic.
package copy_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } copy_state_t;

   localparam int RD_LAT_MAX = 4;

   // Callers truncate the result to their address width, so the wrap is modulo 2^ADDR_W.
   function automatic logic [31:0] dst_addr_at(input logic [31:0] base,
                                               input logic [31:0] idx,
                                               input logic        rev);
      return rev ? (base - idx) : (base + idx);
   endfunction

endpackage

// File: rtl/rom_ram_copy_engine_if.sv
// Control, source-ROM and destination-RAM signals of the copy engine.
// The engine side is master; the requester/memory side is slave.
interface rom_ram_copy_engine_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              start_sig;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [ADDR_W:0]   len;
   logic              reverse;
   logic              busy;
   logic              done_sig;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              write_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;

   modport master (
      input  start_sig, src_base, dst_base, len, reverse, rom_data,
      output busy, done_sig, rom_addr, write_en, ram_addr, ram_data
   );

   modport slave (
      output start_sig, src_base, dst_base, len, reverse, rom_data,
      input  busy, done_sig, rom_addr, write_en, ram_addr, ram_data
   );
endinterface

// File: rtl/rom_ram_copy_engine_delay.sv
// Shift register of {valid, payload} with synchronous clear; output is DEPTH cycles behind input.
// pending flags a valid entry in any stage other than the output stage.
module data_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_dat,
   output logic             pending
);
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         vld <= '0;
         for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
      end else begin
         vld    <= {vld[DEPTH-2:0], in_vld};
         dat[0] <= in_dat;
         for (int k = 1; k < DEPTH; k++) dat[k] <= dat[k-1];
      end
   end

   assign out_vld = vld[DEPTH-1];
   assign out_dat = dat[DEPTH-1];
   assign pending = |vld[DEPTH-2:0];
endmodule

// File: rtl/rom_ram_copy_engine.sv
// Block-copy sequencer: reads len words from a synchronous ROM and writes them to a RAM.
// The destination address rides a delay line so it lands with the registered read data.
module rom_ram_copy_engine
   import copy_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input logic                   clk,
   input logic                   rst,
   rom_ram_copy_engine_if.master bus
);
   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("rom_ram_copy_engine: RD_LAT must be within 1..4");
   end

   copy_state_t       state;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [DATA_W-1:0] ram_data_q;
   logic              issue_vld;
   logic [ADDR_W-1:0] issue_dst;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W:0]   len_q;
   logic              rev_q;
   logic              wr_vld;
   logic [ADDR_W-1:0] wr_addr;
   logic              dly_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rom_addr_q <= '0;
         ram_data_q <= '0;
         issue_vld  <= 1'b0;
         issue_dst  <= '0;
         idx        <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         rev_q      <= 1'b0;
      end else begin
         ram_data_q <= bus.rom_data;
         done_q     <= 1'b0;
         issue_vld  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_sig) begin
                  src_q  <= bus.src_base;
                  dst_q  <= bus.dst_base;
                  len_q  <= bus.len;
                  rev_q  <= bus.reverse;
                  busy_q <= 1'b1;
                  if (bus.len == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     // Index 0 goes out on the accepting edge so reads start one cycle after start.
                     rom_addr_q <= bus.src_base;
                     issue_vld  <= 1'b1;
                     issue_dst  <= bus.dst_base;
                     idx        <= (ADDR_W+1)'(1);
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (idx == len_q) begin
                  state <= DRAIN;
               end else begin
                  rom_addr_q <= src_q + idx[ADDR_W-1:0];
                  issue_vld  <= 1'b1;
                  issue_dst  <= ADDR_W'(dst_addr_at(32'(dst_q), 32'(idx), rev_q));
                  idx        <= idx + (ADDR_W+1)'(1);
               end
            end
            DRAIN: begin
               // Last entry has reached the output stage: its write is on the bus this cycle.
               if (!dly_pending) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   data_delay_line #(
      .DEPTH(RD_LAT + 1),
      .WIDTH(ADDR_W)
   ) u_dly (
      .clk     (clk),
      .clr     (rst),
      .in_vld  (issue_vld),
      .in_dat  (issue_dst),
      .out_vld (wr_vld),
      .out_dat (wr_addr),
      .pending (dly_pending)
   );

   assign bus.busy     = busy_q;
   assign bus.done_sig = done_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.write_en = wr_vld;
   assign bus.ram_addr = wr_addr;
   assign bus.ram_data = ram_data_q;
endmodule

// File: tb/tb_rom_ram_copy_engine.sv
// Runs four engines (RD_LAT 1..4) on shared stimulus; a per-lane scoreboard checks timing and contents.
module tb_rom_ram_copy_engine;
   typedef struct packed {
      int         cyc;
      logic       en;
      logic [3:0] addr;
      logic [7:0] dat;
   } wr_t;

   typedef struct packed {
      int         cyc;
      logic [3:0] addr;
   } rd_t;

   logic       clk;
   logic       rst;
   logic       start_sig;
   logic [3:0] src_base;
   logic [3:0] dst_base;
   logic [4:0] len;
   logic       reverse;

   int   cyc;
   int   checks;
   int   failures;
   bit   mon_en;
   int   rst_chk_cyc;
   int   last_e0;
   int   bs [4];
   int   be [4];
   int   wr_cnt [4][16];
   wr_t  wr_q [4][$];
   rd_t  rom_q [4][$];
   int   done_q [4][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : lane
      rom_ram_copy_engine_if #(.ADDR_W(4), .DATA_W(8)) bif ();
      logic [7:0] pipe [0:g];

      assign bif.start_sig = start_sig;
      assign bif.src_base  = src_base;
      assign bif.dst_base  = dst_base;
      assign bif.len       = len;
      assign bif.reverse   = reverse;
      assign bif.rom_data  = pipe[g];

      // ROM content is a*3; read data appears g+1 cycles after the address.
      always @(posedge clk) begin
         pipe[0] <= {4'd0, bif.rom_addr} * 8'd3;
         for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
      end

      rom_ram_copy_engine #(.ADDR_W(4), .DATA_W(8), .RD_LAT(g + 1)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bif)
      );

      always @(negedge clk) begin
         wr_t got_w;
         wr_t exp_w;
         rd_t exp_r;
         int  exp_d;
         if (mon_en) begin
            if (bif.write_en === 1'b1) wr_cnt[g][bif.ram_addr]++;
            if (bif.write_en !== 1'b0 || (wr_q[g].size() > 0 && wr_q[g][0].cyc == cyc)) begin
               got_w = '{cyc, bif.write_en, bif.ram_addr, bif.ram_data};
               exp_w = '0;
               if (wr_q[g].size() > 0) exp_w = wr_q[g].pop_front();
               checks++;
               assert (got_w === exp_w) else begin
                  failures++;
                  $error("FAIL write lane%0d: got cyc=%0d en=%b addr=%0d dat=%0d expected cyc=%0d en=%b addr=%0d dat=%0d",
                         g, got_w.cyc, got_w.en, got_w.addr, got_w.dat, exp_w.cyc, exp_w.en, exp_w.addr, exp_w.dat);
               end
            end
            if (bif.done_sig !== 1'b0 || (done_q[g].size() > 0 && done_q[g][0] == cyc)) begin
               exp_d = -1;
               if (done_q[g].size() > 0) exp_d = done_q[g].pop_front();
               checks++;
               assert (bif.done_sig === 1'b1 && cyc == exp_d) else begin
                  failures++;
                  $error("FAIL done lane%0d: got done=%b at cyc=%0d expected done at cyc=%0d",
                         g, bif.done_sig, cyc, exp_d);
               end
            end
            if (rom_q[g].size() > 0 && rom_q[g][0].cyc == cyc) begin
               exp_r = rom_q[g].pop_front();
               checks++;
               assert (bif.rom_addr === exp_r.addr) else begin
                  failures++;
                  $error("FAIL rom_addr lane%0d cyc=%0d: got %0d expected %0d", g, cyc, bif.rom_addr, exp_r.addr);
               end
            end
            checks++;
            assert (bif.busy === (cyc >= bs[g] && cyc <= be[g])) else begin
               failures++;
               $error("FAIL busy lane%0d cyc=%0d: got %b expected %b", g, cyc, bif.busy, (cyc >= bs[g] && cyc <= be[g]));
            end
            if (cyc == rst_chk_cyc) begin
               checks++;
               assert ({bif.busy, bif.done_sig, bif.write_en, bif.rom_addr, bif.ram_addr, bif.ram_data} === 19'd0) else begin
                  failures++;
                  $error("FAIL reset_outputs lane%0d: got %h expected 0", g,
                         {bif.busy, bif.done_sig, bif.write_en, bif.rom_addr, bif.ram_addr, bif.ram_data});
               end
            end
         end
      end
   end

   task automatic start_copy(input logic [3:0] s, input logic [3:0] d, input logic [4:0] n, input logic r);
      int         e0;
      int         dc;
      wr_t        w;
      rd_t        ra;
      logic [3:0] sa;
      @(negedge clk);
      e0       = cyc;
      last_e0  = e0;
      src_base = s;
      dst_base = d;
      len      = n;
      reverse  = r;
      start_sig = 1'b1;
      for (int g = 0; g < 4; g++) begin
         for (int i = 0; i < int'(n); i++) begin
            sa      = s + 4'(i);
            w.cyc   = e0 + 2 + (g + 1) + i;
            w.en    = 1'b1;
            w.addr  = r ? (d - 4'(i)) : (d + 4'(i));
            w.dat   = {4'd0, sa} * 8'd3;
            wr_q[g].push_back(w);
            ra.cyc  = e0 + 1 + i;
            ra.addr = sa;
            rom_q[g].push_back(ra);
         end
         dc = (n == 5'd0) ? e0 + 1 : e0 + 2 + (g + 1) + int'(n);
         done_q[g].push_back(dc);
         bs[g] = e0 + 1;
         be[g] = dc;
      end
      @(negedge clk);
      start_sig = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] s, input logic [3:0] d, input logic [4:0] n, input logic r);
      @(negedge clk);
      src_base  = s;
      dst_base  = d;
      len       = n;
      reverse   = r;
      start_sig = 1'b1;
      @(negedge clk);
      start_sig = 1'b0;
   endtask

   task automatic check_drained(input string tag);
      for (int g = 0; g < 4; g++) begin
         checks++;
         assert (wr_q[g].size() + rom_q[g].size() + done_q[g].size() == 0) else begin
            failures++;
            $error("FAIL %s lane%0d: got %0d outstanding expectations expected 0", tag, g,
                   wr_q[g].size() + rom_q[g].size() + done_q[g].size());
         end
      end
   endtask

   initial begin
      logic [15:0] mask;
      int          r_cyc;
      rst = 1'b1; start_sig = 1'b0; src_base = '0; dst_base = '0; len = '0; reverse = 1'b0;
      checks = 0; failures = 0; mon_en = 1'b0; rst_chk_cyc = -1; last_e0 = 0;
      for (int g = 0; g < 4; g++) begin
         bs[g] = 1; be[g] = 0;
      end
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      rst_chk_cyc = cyc + 1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      start_copy(4'd2, 4'd8, 5'd4, 1'b0);
      repeat (14) @(negedge clk);
      check_drained("basic");

      start_copy(4'd14, 4'd1, 5'd4, 1'b1);
      repeat (14) @(negedge clk);
      check_drained("reverse_wrap");

      start_copy(4'd3, 4'd3, 5'd0, 1'b0);
      repeat (6) @(negedge clk);
      check_drained("len_zero");

      for (int g = 0; g < 4; g++)
         for (int a = 0; a < 16; a++) wr_cnt[g][a] = 0;
      start_copy(4'd5, 4'd3, 5'd16, 1'b0);
      repeat (26) @(negedge clk);
      check_drained("len_full");
      for (int g = 0; g < 4; g++) begin
         for (int a = 0; a < 16; a++) mask[a] = (wr_cnt[g][a] == 1);
         checks++;
         assert (mask === 16'hFFFF) else begin
            failures++;
            $error("FAIL full_coverage lane%0d: got once-written mask %h expected ffff", g, mask);
         end
      end

      // Start pulses while busy (ISSUE, then DRAIN) must neither queue nor disturb the copy.
      start_copy(4'd0, 4'd0, 5'd5, 1'b0);
      pulse_start(4'd9, 4'd4, 5'd3, 1'b1);
      repeat (2) @(negedge clk);
      pulse_start(4'd11, 4'd6, 5'd2, 1'b0);
      repeat (10) @(negedge clk);
      check_drained("busy_start");

      start_copy(4'd2, 4'd8, 5'd4, 1'b0);
      repeat (3) @(negedge clk);
      rst   = 1'b1;
      r_cyc = last_e0 + 5;
      for (int g = 0; g < 4; g++) begin
         while (wr_q[g].size() > 0 && wr_q[g][$].cyc >= r_cyc) void'(wr_q[g].pop_back());
         while (rom_q[g].size() > 0 && rom_q[g][$].cyc >= r_cyc) void'(rom_q[g].pop_back());
         while (done_q[g].size() > 0 && done_q[g][$] >= r_cyc) void'(done_q[g].pop_back());
         be[g] = r_cyc - 1;
      end
      rst_chk_cyc = r_cyc;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check_drained("reset_abort");

      start_copy(4'd7, 4'd12, 5'd3, 1'b1);
      repeat (12) @(negedge clk);
      check_drained("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
